hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Decode-stage hazard and stall controller for the five-stage pipeline. Consumes the destination-register ("changed register") values produced for instructions in later stages, together with the multdiv issue/completion handshake, and decides whether the instruction in F/D may advance. Tracks one outstanding multicycle multdiv write in a per-register pending scoreboard. Detects load-use, pending-write, WAW and multdiv structural hazards. Drives the global `stall` seen by the PC, F/D and D/X latches.

## Interface
Parameters:
- `MD_TIMEOUT`, 64: cycles in BUSY without `md_ready` before the watchdog fires; legal range 2–255.

Ports:
- `clock`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `fd_insn`  in  32  instruction currently in F/D.
- `dx_wr_reg`  in  5  changed register of the instruction in D/X (0 = none).
- `dx_is_load`  in  1  D/X instruction is `lw` (opcode 01000).
- `md_start`  in  1  multdiv operation launched from X this cycle.
- `md_wr_reg`  in  5  destination of the launched multdiv.
- `md_ready`  in  1  multdiv result written back this cycle (1-cycle pulse).
- `stall`  out  1  hold PC and F/D, insert bubble into D/X.
- `md_busy`  out  1  FSM in BUSY.
- `pending`  out  32  scoreboard, bit i = write to r[i] outstanding.
- `md_err`  out  1  sticky: overrun or watchdog timeout.
- `stall_cycles`  out  16  stall counter (only with `HAZARD_PERF_CNT_EN`).

## Operation
- Source extraction from `fd_insn` (opcode = [31:27]):
  - rs = [21:17] for every opcode;
  - rt = [16:12] only for opcode 00000;
  - rd = [26:22] as a *source* for 00111 (sw), 00010 (bne), 00110 (blt), 00100 (jr).
  - Any source equal to 0 never causes a hazard.
- Stall is asserted when any of the following hold:
  - **load-use:** `dx_is_load` and `dx_wr_reg != 0` and `dx_wr_reg` equals a valid source.
  - **RAW pending:** `pending_eff[src]` is set for a valid source, where `pending_eff = pending & ~clear_mask`; `clear_mask` is the one-hot of the BUSY destination when `md_ready` = 1 this cycle (same-cycle release).
  - **WAW:** the F/D instruction's destination (per the changed-register rules: 00000/00101/01000 → [26:22], 00011 → 31, 10101 → 30) is nonzero and `pending_eff` is set for it.
  - **structural:** F/D opcode 00000 with ALU op [6:2] = 00110/00111 (mul/div) while `md_busy` and not `md_ready`.
- `stall` is combinational from the inputs and registered state. `pending` is forced to 0 for r0.
- FSM states IDLE, BUSY, TIMEOUT:
  - IDLE → BUSY on `md_start`: latch `md_wr_reg`, set its pending bit (unless 0), clear the watchdog counter.
  - BUSY → IDLE on `md_ready`: clear the latched register's bit.
  - BUSY with `md_ready` and `md_start` in the same cycle: clear the old bit, set the new one, remain in BUSY, reset the counter. If both name the same register, the set wins.
  - BUSY → TIMEOUT when the counter reaches `MD_TIMEOUT`. TIMEOUT lasts exactly one cycle, clears all pending bits, sets `md_err`, then → IDLE.
  - `md_start` in BUSY without `md_ready` = overrun: set `md_err`, ignore the request.
- `md_err` clears only on reset.

## Timing
- Reset values: `stall` is combinational; with reset low, `fd_insn` and D/X inputs still evaluate, and scoreboard contributions are 0. `md_busy` = 0, `pending` = 0, `md_err` = 0, `stall_cycles` = 0, state IDLE.
- `md_start` at edge N → `pending` bit and `md_busy` visible after edge N.
- `md_ready` in cycle N releases a dependent F/D instruction in cycle N (no stall). The bit is cleared at edge N.
- Watchdog counter is 8-bit, increments each BUSY cycle, saturates.
- Reset asserted mid-BUSY: immediate return to IDLE with the scoreboard cleared.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cycles` increments at each edge where `stall` = 1;
  - saturates at 16'hFFFF;
  - reset to 0.
- Undefined: the counter logic is absent and `stall_cycles` is tied to 0.

## Structure
- `hazard_pkg`:
  - opcode constants (ALU, ADDI, LW, SW, BNE, BLT, JR, JAL, SETX);
  - ALU mul/div op codes;
  - register constants R_RA = 31, R_STATUS = 30;
  - FSM state enum;
  - default `MD_TIMEOUT`.
- Sub-module `src_reg_decode`: combinational `fd_insn` → rs/rt/rd-source values with valid bits, plus F/D destination. Reused by the bypass unit.

## Test plan
- D/X `lw` r5 (`dx_is_load` = 1, `dx_wr_reg` = 5), F/D `add r7,r5,r2` → `stall` = 1 for that cycle; with `dx_wr_reg` = 0 or F/D `addi r5,r0,1` reading r0 → `stall` = 0.
- `md_start` with `md_wr_reg` = 9, then F/D `sub r1,r9,r3` → `stall` = 1 each cycle until `md_ready`; in the `md_ready` cycle `stall` = 0; `pending[9]` = 0 after that edge.
- BUSY on r4, F/D `addi r4,r1,2` → WAW `stall` = 1; F/D `jal` while r31 pending → `stall` = 1.
- `md_start` to r8 held without `md_ready` for 64 cycles → one TIMEOUT cycle, then `pending` = 0, `md_err` = 1, `md_busy` = 0.
- Back-to-back: `md_ready` (r3) and `md_start` (r3) in the same cycle → `pending[3]` stays 1, `md_busy` stays 1; second `md_start` while busy without ready → `md_err` = 1.
- With `HAZARD_PERF_CNT_EN`: 5 stall cycles → `stall_cycles` = 5. Drop `reset` low mid-BUSY → all outputs at reset values immediately.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants, FSM state type and helpers for the decode-stage hazard scoreboard.
package hazard_pkg;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_SETX = 5'b10101;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [4:0] R_RA     = 5'd31;
  localparam logic [4:0] R_STATUS = 5'd30;

  localparam int MD_TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_TIMEOUT = 2'd2
  } md_state_e;

  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    reg_onehot = 32'd1 << r;
  endfunction

endpackage

// File: rtl/src_reg_decode.sv
// Combinational F/D source/destination register extraction; shared with the bypass unit.
module src_reg_decode
  import hazard_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic [4:0]  rs_o,
  output logic        rs_v_o,
  output logic [4:0]  rt_o,
  output logic        rt_v_o,
  output logic [4:0]  rd_o,
  output logic        rd_v_o,
  output logic [4:0]  dst_o,
  output logic        is_muldiv_o
);

  logic [4:0] opcode;
  logic [4:0] aluop;
  logic       unused_bits;

  // Shamt and the low two bits never name a register.
  assign unused_bits = ^{insn_i[11:7], insn_i[1:0]};

  always_comb begin
    opcode = insn_i[31:27];
    aluop  = insn_i[6:2];
    rs_o   = insn_i[21:17];
    rt_o   = insn_i[16:12];
    rd_o   = insn_i[26:22];

    rs_v_o = (rs_o != 5'd0);
    rt_v_o = (opcode == OP_ALU) && (rt_o != 5'd0);
    rd_v_o = ((opcode == OP_SW) || (opcode == OP_BNE) ||
              (opcode == OP_BLT) || (opcode == OP_JR)) && (rd_o != 5'd0);

    case (opcode)
      OP_ALU, OP_ADDI, OP_LW: dst_o = rd_o;
      OP_JAL:                 dst_o = R_RA;
      OP_SETX:                dst_o = R_STATUS;
      default:                dst_o = 5'd0;
    endcase

    is_muldiv_o = (opcode == OP_ALU) && ((aluop == ALU_MUL) || (aluop == ALU_DIV));
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall controller with a one-deep multdiv pending-write scoreboard.
// Optional stall counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = MD_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] fd_insn,
  input  logic [4:0]  dx_wr_reg,
  input  logic        dx_is_load,
  input  logic        md_start,
  input  logic [4:0]  md_wr_reg,
  input  logic        md_ready,
  output logic        stall,
  output logic        md_busy,
  output logic [31:0] pending,
  output logic        md_err,
  output logic [15:0] stall_cycles
);

  localparam logic [7:0] TO_CNT = 8'(MD_TIMEOUT);

  md_state_e   state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  busy_reg_q, busy_reg_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;

  logic [4:0]  rs, rt, rd, dst;
  logic        rs_v, rt_v, rd_v, is_muldiv;
  logic [31:0] clear_mask, pending_eff;
  logic        load_use, raw_pend, waw, structural;

  src_reg_decode u_decode (
    .insn_i      (fd_insn),
    .rs_o        (rs),
    .rs_v_o      (rs_v),
    .rt_o        (rt),
    .rt_v_o      (rt_v),
    .rd_o        (rd),
    .rd_v_o      (rd_v),
    .dst_o       (dst),
    .is_muldiv_o (is_muldiv)
  );

  // A result landing this cycle releases its dependants in the same cycle.
  assign clear_mask  = (state_q == ST_BUSY && md_ready) ? reg_onehot(busy_reg_q) : 32'd0;
  assign pending_eff = pending_q & ~clear_mask;

  always_comb begin
    load_use   = dx_is_load && (dx_wr_reg != 5'd0) &&
                 ((rs_v && rs == dx_wr_reg) || (rt_v && rt == dx_wr_reg) ||
                  (rd_v && rd == dx_wr_reg));
    raw_pend   = (rs_v && pending_eff[rs]) || (rt_v && pending_eff[rt]) ||
                 (rd_v && pending_eff[rd]);
    waw        = (dst != 5'd0) && pending_eff[dst];
    structural = is_muldiv && (state_q == ST_BUSY) && !md_ready;
    stall      = load_use || raw_pend || waw || structural;
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    busy_reg_d = busy_reg_q;
    wd_cnt_d   = wd_cnt_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (md_start) begin
          state_d    = ST_BUSY;
          busy_reg_d = md_wr_reg;
          pending_d  = pending_q | reg_onehot(md_wr_reg);
          wd_cnt_d   = 8'd0;
        end
      end
      ST_BUSY: begin
        if (md_ready) begin
          pending_d = pending_eff;
          if (md_start) begin
            // Set after clear so a repeat of the same register stays pending.
            pending_d  = pending_eff | reg_onehot(md_wr_reg);
            busy_reg_d = md_wr_reg;
            wd_cnt_d   = 8'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (md_start) err_d = 1'b1;
          if (wd_cnt_q != 8'hFF) wd_cnt_d = wd_cnt_q + 8'd1;
          if (wd_cnt_d == TO_CNT) state_d = ST_TIMEOUT;
        end
      end
      ST_TIMEOUT: begin
        pending_d = 32'd0;
        err_d     = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pending_q  <= 32'd0;
      busy_reg_q <= 5'd0;
      wd_cnt_q   <= 8'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      busy_reg_q <= busy_reg_d;
      wd_cnt_q   <= wd_cnt_d;
      err_q      <= err_d;
    end
  end

  assign md_busy = (state_q == ST_BUSY);
  assign pending = pending_q;
  assign md_err  = err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) stall_cnt_q <= 16'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: expectations queued when stimulus is driven.
module tb_hazard_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] fd_insn;
  logic [4:0]  dx_wr_reg;
  logic        dx_is_load;
  logic        md_start;
  logic [4:0]  md_wr_reg;
  logic        md_ready;
  logic        stall;
  logic        md_busy;
  logic [31:0] pending;
  logic        md_err;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  localparam int K_STALL = 0, K_BUSY = 1, K_PEND = 2, K_ERR = 3, K_SCNT = 4;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] v;
  } exp_t;

  exp_t sb_q[$];

  hazard_scoreboard #(.MD_TIMEOUT(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .fd_insn      (fd_insn),
    .dx_wr_reg    (dx_wr_reg),
    .dx_is_load   (dx_is_load),
    .md_start     (md_start),
    .md_wr_reg    (md_wr_reg),
    .md_ready     (md_ready),
    .stall        (stall),
    .md_busy      (md_busy),
    .pending      (pending),
    .md_err       (md_err),
    .stall_cycles (stall_cycles)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] aluop);
    rtype = {5'b00000, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] itype(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [16:0] imm);
    itype = {op, rd, rs, imm};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic expect_v(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.v = v;
    sb_q.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    logic [31:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_STALL: obs = {31'd0, stall};
        K_BUSY:  obs = {31'd0, md_busy};
        K_PEND:  obs = pending;
        K_ERR:   obs = {31'd0, md_err};
        default: obs = {16'd0, stall_cycles};
      endcase
      check_val(e.tag, obs, e.v);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic cyc();
    check_all();
    tick();
  endtask

  localparam logic [31:0] NOP = 32'd0;
  localparam logic [31:0] JAL = {5'b00011, 27'd100};

  initial begin
    reset = 1'b0; md_start = 1'b0; md_wr_reg = 5'd0; md_ready = 1'b0;
    dx_is_load = 1'b1; dx_wr_reg = 5'd5; fd_insn = rtype(5'd7, 5'd5, 5'd2, 5'd0);

    // Reset: stall still combinational from inputs, registered outputs cleared.
    expect_v("rst_stall", K_STALL, 32'd1);
    expect_v("rst_busy",  K_BUSY,  32'd0);
    expect_v("rst_pend",  K_PEND,  32'd0);
    expect_v("rst_err",   K_ERR,   32'd0);
    expect_v("rst_scnt",  K_SCNT,  32'd0);
    check_all();

    @(negedge clock);
    reset = 1'b1; fd_insn = NOP; dx_is_load = 1'b0; dx_wr_reg = 5'd0;

    // Five cycles of load-use stall feed the counter.
    dx_is_load = 1'b1; dx_wr_reg = 5'd5; fd_insn = rtype(5'd7, 5'd5, 5'd2, 5'd0);
    expect_v("lu_rs", K_STALL, 32'd1);
    check_all();
    repeat (5) tick();
    fd_insn = NOP; dx_is_load = 1'b0; dx_wr_reg = 5'd0;
`ifdef HAZARD_PERF_CNT_EN
    expect_v("perf_cnt", K_SCNT, 32'd5);
`else
    expect_v("perf_cnt", K_SCNT, 32'd0);
`endif
    expect_v("nop_stall", K_STALL, 32'd0);
    cyc();

    dx_is_load = 1'b1; dx_wr_reg = 5'd0; fd_insn = rtype(5'd7, 5'd5, 5'd2, 5'd0);
    expect_v("lu_dx0", K_STALL, 32'd0);
    cyc();
    dx_wr_reg = 5'd5; fd_insn = itype(5'b00101, 5'd5, 5'd0, 17'd1);
    expect_v("lu_addi_r0", K_STALL, 32'd0);
    cyc();
    fd_insn = itype(5'b00111, 5'd5, 5'd1, 17'd0);
    expect_v("lu_sw_rd", K_STALL, 32'd1);
    cyc();
    fd_insn = itype(5'b00101, 5'd1, 5'd2, 17'h05000);
    expect_v("lu_addi_imm", K_STALL, 32'd0);
    cyc();
    fd_insn = rtype(5'd7, 5'd2, 5'd5, 5'd0);
    expect_v("lu_rt", K_STALL, 32'd1);
    cyc();
    dx_is_load = 1'b0; dx_wr_reg = 5'd5;
    expect_v("nolu_rt", K_STALL, 32'd0);
    cyc();
    dx_wr_reg = 5'd0; fd_insn = NOP;

    // RAW on a pending multdiv result, released in the ready cycle.
    md_start = 1'b1; md_wr_reg = 5'd9;
    expect_v("md9_start_stall", K_STALL, 32'd0);
    cyc();
    md_start = 1'b0; fd_insn = rtype(5'd1, 5'd9, 5'd3, 5'd1);
    expect_v("md9_busy",  K_BUSY,  32'd1);
    expect_v("md9_pend",  K_PEND,  32'h0000_0200);
    expect_v("raw9_c0",   K_STALL, 32'd1);
    cyc();
    for (int i = 0; i < 2; i++) begin
      expect_v("raw9_hold", K_STALL, 32'd1);
      cyc();
    end
    md_ready = 1'b1;
    expect_v("raw9_ready", K_STALL, 32'd0);
    cyc();
    md_ready = 1'b0;
    expect_v("md9_idle", K_BUSY,  32'd0);
    expect_v("md9_clr",  K_PEND,  32'd0);
    expect_v("raw9_off", K_STALL, 32'd0);
    cyc();

    // WAW on r4 and on the implicit r31 of jal; structural mul while busy.
    fd_insn = NOP; md_start = 1'b1; md_wr_reg = 5'd4;
    cyc();
    md_start = 1'b0; fd_insn = itype(5'b00101, 5'd4, 5'd1, 17'd2);
    expect_v("waw_r4",  K_STALL, 32'd1);
    expect_v("pend_r4", K_PEND,  32'h0000_0010);
    cyc();
    fd_insn = JAL;
    expect_v("jal_r4", K_STALL, 32'd0);
    cyc();
    md_ready = 1'b1; md_start = 1'b1; md_wr_reg = 5'd31;
    expect_v("jal_swap", K_STALL, 32'd0);
    cyc();
    md_ready = 1'b0; md_start = 1'b0;
    expect_v("pend_r31", K_PEND,  32'h8000_0000);
    expect_v("busy_r31", K_BUSY,  32'd1);
    expect_v("waw_jal",  K_STALL, 32'd1);
    cyc();
    fd_insn = rtype(5'd1, 5'd2, 5'd3, 5'b00110);
    expect_v("struct_mul", K_STALL, 32'd1);
    cyc();
    md_ready = 1'b1;
    expect_v("struct_rdy", K_STALL, 32'd0);
    cyc();
    md_ready = 1'b0; fd_insn = NOP;
    expect_v("r31_idle", K_BUSY, 32'd0);
    expect_v("r31_clr",  K_PEND, 32'd0);
    cyc();

    // Back-to-back on r3, then overrun.
    md_start = 1'b1; md_wr_reg = 5'd3;
    cyc();
    md_ready = 1'b1;
    cyc();
    md_ready = 1'b0; md_start = 1'b0;
    expect_v("b2b_pend", K_PEND, 32'h0000_0008);
    expect_v("b2b_busy", K_BUSY, 32'd1);
    expect_v("b2b_err",  K_ERR,  32'd0);
    cyc();
    md_start = 1'b1; md_wr_reg = 5'd6;
    cyc();
    md_start = 1'b0;
    expect_v("ovr_err",  K_ERR,  32'd1);
    expect_v("ovr_pend", K_PEND, 32'h0000_0008);
    expect_v("ovr_busy", K_BUSY, 32'd1);
    cyc();

    // Reset mid-BUSY takes effect without a clock edge.
    reset = 1'b0;
    expect_v("mrst_busy", K_BUSY, 32'd0);
    expect_v("mrst_pend", K_PEND, 32'd0);
    expect_v("mrst_err",  K_ERR,  32'd0);
    expect_v("mrst_scnt", K_SCNT, 32'd0);
    cyc();
    reset = 1'b1;

    // Watchdog: 64 BUSY cycles, one TIMEOUT cycle, then IDLE with error.
    md_start = 1'b1; md_wr_reg = 5'd8;
    cyc();
    md_start = 1'b0;
    repeat (63) tick();
    expect_v("wd_busy64", K_BUSY, 32'd1);
    expect_v("wd_pend64", K_PEND, 32'h0000_0100);
    expect_v("wd_err64",  K_ERR,  32'd0);
    cyc();
    expect_v("wd_to_busy", K_BUSY, 32'd0);
    cyc();
    expect_v("wd_busy", K_BUSY, 32'd0);
    expect_v("wd_pend", K_PEND, 32'd0);
    expect_v("wd_err",  K_ERR,  32'd1);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
